instr_seq: RTL and testbench
============================

INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 SHALL have parameters: PC_WIDTH, default 8, program counter width; VALUE_WIDTH, default 8, operand/address field width; OPCODE_WIDTH, default 6, opcode width; STACK_DEPTH, default 8, call-stack entries tracked.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: run  in  1  level; start or continue execution.
REQ-005 SHALL have ports: instr_rdata  in  IW  program word, valid one cycle after instr_addr; IW = OPCODE_WIDTH+3*VALUE_WIDTH+6.
REQ-006 SHALL have ports: zero_flag  in  1  ALU zero flag from the last executed ALU op.
REQ-007 SHALL have ports: ret_addr  in  PC_WIDTH  return address from the datapath stack, valid the cycle after pop.
REQ-008 SHALL have ports: instr_addr  out  PC_WIDTH  program address / pushed return address.
REQ-009 SHALL have ports: op_code  out  OPCODE_WIDTH; source1, source2, destination  out  VALUE_WIDTH each; source1_choice, source2_choice, destination_choice  out  2 each.
REQ-010 SHALL have ports: push, pop  out  1  one-cycle datapath stack strobes.
REQ-011 SHALL have ports: halted  out  1  HALT executed; fault  out  1  stack overflow/underflow; busy  out  1  state != IDLE and != STOP.

Function
REQ-012 SHALL decode the word MSB-first as: op, s1_choice, s1, s2_choice, s2, d_choice, d.
REQ-013 SHALL implement states IDLE, FETCH, LOAD, EXEC, RETW, STOP.
REQ-014 IDLE -> FETCH when run=1; otherwise stay.
REQ-015 FETCH: drive instr_addr=pc for one cycle -> LOAD.
REQ-016 LOAD: latch instr_rdata into an instruction register -> EXEC.
REQ-017 EXEC SHALL last one cycle; the decoded fields drive the outputs only in EXEC; in every other state op_code=OP_NOP, all fields/choices=0, and push=pop=0.
REQ-018 ALU op (any code not listed below): pc<=pc+1, next FETCH.
REQ-019 OP_JMP: pc<=d[PC_WIDTH-1:0], zero-extended if VALUE_WIDTH<PC_WIDTH.
REQ-020 OP_JZ: pc<=d when zero_flag=1 in the EXEC cycle, else pc+1.
REQ-021 OP_CALL: instr_addr=pc+1 and push=1 in EXEC, depth+1, pc<=d.
REQ-022 OP_RET: pop=1 in EXEC, depth-1 -> RETW; in RETW pc<=ret_addr -> FETCH.
REQ-023 OP_HALT: -> STOP, halted=1 until reset.
REQ-024 Every instruction SHALL take 3 cycles FETCH-to-FETCH; RET takes 4.
REQ-025 pc arithmetic SHALL wrap modulo 2^PC_WIDTH (max+1 = 0).
REQ-026 CALL when depth==STACK_DEPTH, or RET when depth==0: suppress push/pop, set fault=1, go to STOP.
REQ-027 run=0 SHALL be sampled only in FETCH: go to IDLE with pc held; an instruction in LOAD/EXEC/RETW always completes.
REQ-028 In IDLE, instr_addr SHALL show pc; in STOP it SHALL hold its last value.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, pc=0, depth=0, halted=0, fault=0, push=pop=0, op_code=OP_NOP, all other outputs 0, including mid-instruction; operation resumes on the first edge after release.

Structure
REQ-030 instructions package SHALL hold OPCODE_WIDTH, VALUE_WIDTH, PC_WIDTH, the state enum, and opcodes OP_NOP=0x00, OP_JMP=0x30, OP_JZ=0x31, OP_CALL=0x32, OP_RET=0x33, OP_HALT=0x3F.
REQ-031 Field slicing and opcode classification SHALL be one combinational sub-module, instr_decode; FSM, pc and depth counter stay in instr_seq.

Verification
REQ-032 Reset mid-EXEC of ALU op 0x01 -> next cycle all outputs 0, op_code=0x00, instr_addr=0.
REQ-033 Program {ALU 0x01, JMP d=0x05} at pc 0 -> instr_addr sequence 0,1,5; ALU fields visible only in EXEC cycle 3.
REQ-034 JZ d=0x10 with zero_flag=1 -> pc=0x10; with zero_flag=0 -> pc=pc+1.
REQ-035 CALL d=0x20 at pc 3 -> push=1 for one cycle with instr_addr=4; RET at 0x20 with ret_addr=4 -> pop=1, 4-cycle RET, next fetch at 4.
REQ-036 STACK_DEPTH=2, three nested CALLs -> third has no push, fault=1, STOP; RET at depth 0 -> fault=1, no pop.
REQ-037 JMP d=0xFF then ALU op at 0xFF -> next fetch address 0x00; HALT -> halted=1, busy=0, run ignored.

Source files
------------

// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: shared widths, sequencer states, opcode classes and opcode values
package instr_seq_pkg;
  localparam int PC_WIDTH = 8;
  localparam int VALUE_WIDTH = 8;
  localparam int OPCODE_WIDTH = 6;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_EXEC, S_RETW, S_STOP} state_t;
  typedef enum logic [2:0] {C_ALU, C_JMP, C_JZ, C_CALL, C_RET, C_HALT} op_class_t;
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 6'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 6'h30;
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ   = 6'h31;
  localparam logic [OPCODE_WIDTH-1:0] OP_CALL = 6'h32;
  localparam logic [OPCODE_WIDTH-1:0] OP_RET  = 6'h33;
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 6'h3F;
endpackage

// File: rtl/instr_seq_if.sv
// instr_seq_if: program memory, decoded-field and datapath-stack bus of the sequencer
interface instr_seq_if #(
  parameter int PC_WIDTH = instr_seq_pkg::PC_WIDTH,
  parameter int VALUE_WIDTH = instr_seq_pkg::VALUE_WIDTH,
  parameter int OPCODE_WIDTH = instr_seq_pkg::OPCODE_WIDTH
);
  logic [PC_WIDTH-1:0] instr_addr;
  logic [OPCODE_WIDTH+3*VALUE_WIDTH+5:0] instr_rdata;
  logic [OPCODE_WIDTH-1:0] op_code;
  logic [VALUE_WIDTH-1:0] source1, source2, destination;
  logic [1:0] source1_choice, source2_choice, destination_choice;
  logic push, pop, zero_flag;
  logic [PC_WIDTH-1:0] ret_addr;
  modport master (
    output instr_addr, op_code, source1, source2, destination,
           source1_choice, source2_choice, destination_choice, push, pop,
    input  instr_rdata, zero_flag, ret_addr
  );
  modport slave (
    input  instr_addr, op_code, source1, source2, destination,
           source1_choice, source2_choice, destination_choice, push, pop,
    output instr_rdata, zero_flag, ret_addr
  );
endinterface

// File: rtl/instr_seq_decode.sv
// instr_decode: slices an instruction word into fields and classifies its opcode
module instr_decode #(
  parameter int VALUE_WIDTH = instr_seq_pkg::VALUE_WIDTH,
  parameter int OPCODE_WIDTH = instr_seq_pkg::OPCODE_WIDTH
) (
  input  logic [OPCODE_WIDTH+3*VALUE_WIDTH+5:0] ir,
  output logic [OPCODE_WIDTH-1:0] op,
  output logic [1:0] s1_choice, s2_choice, d_choice,
  output logic [VALUE_WIDTH-1:0] s1, s2, d,
  output instr_seq_pkg::op_class_t cls
);
  import instr_seq_pkg::*;
  assign {op, s1_choice, s1, s2_choice, s2, d_choice, d} = ir;
  // anything that is not a control-flow opcode is an ALU op
  always_comb
    cls = op == OPCODE_WIDTH'(OP_JMP)  ? C_JMP  :
          op == OPCODE_WIDTH'(OP_JZ)   ? C_JZ   :
          op == OPCODE_WIDTH'(OP_CALL) ? C_CALL :
          op == OPCODE_WIDTH'(OP_RET)  ? C_RET  :
          op == OPCODE_WIDTH'(OP_HALT) ? C_HALT : C_ALU;
endmodule

// File: rtl/instr_seq.sv
// instr_seq: fetch/load/execute sequencer with pc, call-depth tracking and halt/fault stop
module instr_seq #(
  parameter int PC_WIDTH = instr_seq_pkg::PC_WIDTH,
  parameter int VALUE_WIDTH = instr_seq_pkg::VALUE_WIDTH,
  parameter int OPCODE_WIDTH = instr_seq_pkg::OPCODE_WIDTH,
  parameter int STACK_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  instr_seq_if.master bus,
  output logic halted,
  output logic fault,
  output logic busy
);
  import instr_seq_pkg::*;
  localparam int IW = OPCODE_WIDTH + 3 * VALUE_WIDTH + 6;
  localparam int DW = $clog2(STACK_DEPTH + 1);
  state_t state;
  op_class_t cls;
  logic [PC_WIDTH-1:0] pc, pc_inc, addr_q;
  logic [DW-1:0] depth;
  logic [IW-1:0] ir;
  logic [OPCODE_WIDTH-1:0] op;
  logic [1:0] s1c, s2c, dc;
  logic [VALUE_WIDTH-1:0] s1, s2, d;
  logic exec, full, empty, is_call;
  instr_decode #(.VALUE_WIDTH(VALUE_WIDTH), .OPCODE_WIDTH(OPCODE_WIDTH)) u_dec (
    .ir(ir), .op(op), .s1_choice(s1c), .s2_choice(s2c), .d_choice(dc),
    .s1(s1), .s2(s2), .d(d), .cls(cls)
  );
  assign exec = state == S_EXEC;
  assign is_call = exec && cls == C_CALL;
  assign pc_inc = pc + PC_WIDTH'(1);
  assign full = depth == DW'(STACK_DEPTH);
  assign empty = depth == '0;
  assign busy = state != S_IDLE && state != S_STOP;
  // decoded fields are visible only during EXEC; a CALL publishes its return address
  always_comb begin
    bus.op_code = exec ? op : OPCODE_WIDTH'(OP_NOP);
    bus.source1_choice = exec ? s1c : '0;
    bus.source1 = exec ? s1 : '0;
    bus.source2_choice = exec ? s2c : '0;
    bus.source2 = exec ? s2 : '0;
    bus.destination_choice = exec ? dc : '0;
    bus.destination = exec ? d : '0;
    bus.push = is_call && !full;
    bus.pop = exec && cls == C_RET && !empty;
    bus.instr_addr = state == S_STOP ? addr_q : is_call ? pc_inc : pc;
  end
  // remember the last driven address so STOP can keep showing it
  always_ff @(posedge clk or negedge rst)
    if (!rst) addr_q <= '0;
    else addr_q <= bus.instr_addr;
  // sequencer: run is only honoured in FETCH so a started instruction always completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      pc <= '0;
      depth <= '0;
      ir <= '0;
      halted <= 1'b0;
      fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= run ? S_FETCH : S_IDLE;
        S_FETCH: state <= run ? S_LOAD : S_IDLE;
        S_LOAD: begin
          ir <= bus.instr_rdata;
          state <= S_EXEC;
        end
        S_EXEC:
          case (cls)
            C_HALT: begin
              halted <= 1'b1;
              state <= S_STOP;
            end
            C_CALL:
              if (full) begin
                fault <= 1'b1;
                state <= S_STOP;
              end else begin
                depth <= depth + DW'(1);
                pc <= PC_WIDTH'(d);
                state <= S_FETCH;
              end
            C_RET:
              if (empty) begin
                fault <= 1'b1;
                state <= S_STOP;
              end else begin
                depth <= depth - DW'(1);
                state <= S_RETW;
              end
            default: begin
              pc <= (cls == C_JMP || (cls == C_JZ && bus.zero_flag)) ? PC_WIDTH'(d) : pc_inc;
              state <= S_FETCH;
            end
          endcase
        S_RETW: begin
          pc <= bus.ret_addr;
          state <= S_FETCH;
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_seq.sv
// tb_instr_seq: random and directed programs checked cycle-by-cycle against an instruction-level model
module tb_instr_seq;
  import instr_seq_pkg::*;
  localparam int SD = 2;
  logic clk = 1'b0, rst = 1'b0, run = 1'b0;
  logic halted, fault, busy;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic run;
    logic zf;
    logic [7:0] addr;
    logic [35:0] fld;
    logic [4:0] ctl;
  } cyc_t;
  cyc_t q[$];
  logic [35:0] mem [256];
  logic [7:0] dstk[$];
  instr_seq_if bus ();
  instr_seq #(.STACK_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .run(run), .bus(bus),
    .halted(halted), .fault(fault), .busy(busy)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic [5:0] op, input logic [7:0] d);
    return {op, 22'($urandom), d};
  endfunction

  task automatic fill(input bit rnd);
    for (int i = 0; i < 256; i++) begin
      int r;
      logic [5:0] op;
      r = $urandom % 10;
      op = r < 4 ? 6'($urandom) : r == 4 ? OP_JMP : r == 5 ? OP_JZ : r == 6 ? OP_CALL :
           r == 7 ? OP_RET : r == 8 ? OP_NOP : ($urandom % 3 == 0) ? OP_HALT : 6'h2A;
      mem[i] = rnd ? mk(op, 8'($urandom)) : mk(OP_HALT, 8'h00);
    end
  endtask

  task automatic add(input logic r, input logic [7:0] a, input logic [35:0] f, input logic [4:0] c);
    cyc_t e;
    e.run = r;
    e.zf = 1'($urandom);
    e.addr = a;
    e.fld = f;
    e.ctl = c;
    q.push_back(e);
  endtask

  // expected outputs per cycle (ctl = push,pop,busy,halted,fault), built one instruction at a time
  task automatic build(input int n, input int pause_at, input int plen);
    logic [7:0] pc, ea;
    logic [7:0] stk[$];
    logic [35:0] w;
    logic [5:0] op;
    logic stop, h, f, zf;
    int depth;
    pc = 8'h00; ea = 8'h00; depth = 0; stop = 0; h = 0; f = 0;
    q.delete();
    add(1'b1, pc, '0, 5'b00000);
    for (int k = 0; k < n && !stop; k++) begin
      w = mem[pc];
      op = w[35:30];
      if (k == pause_at) begin
        add(1'b0, pc, '0, 5'b00100);
        for (int j = 0; j < plen; j++) add(1'b0, pc, '0, 5'b00000);
        add(1'b1, pc, '0, 5'b00000);
      end
      add(1'b1, pc, '0, 5'b00100);
      add(1'($urandom), pc, '0, 5'b00100);
      ea = op == OP_CALL ? pc + 8'd1 : pc;
      add(1'($urandom), ea, w, {op == OP_CALL && depth < SD, op == OP_RET && depth > 0, 3'b100});
      zf = q[$].zf;
      if (op == OP_HALT) begin
        stop = 1; h = 1;
      end else if (op == OP_CALL) begin
        if (depth == SD) begin stop = 1; f = 1; end
        else begin stk.push_back(pc + 8'd1); depth++; pc = w[7:0]; end
      end else if (op == OP_RET) begin
        if (depth == 0) begin stop = 1; f = 1; end
        else begin add(1'($urandom), pc, '0, 5'b00100); pc = stk.pop_back(); depth--; end
      end else if (op == OP_JMP) pc = w[7:0];
      else if (op == OP_JZ) pc = zf ? w[7:0] : pc + 8'd1;
      else pc = pc + 8'd1;
    end
    if (stop) repeat (4) add(1'($urandom), ea, '0, {3'b000, h, f});
  endtask

  task automatic run_prog(input int n, input int pause_at, input int plen);
    logic [7:0] prev;
    prev = 8'h00;
    build(n, pause_at, plen);
    rst = 1'b0; run = 1'b0;
    dstk.delete();
    bus.ret_addr = '0; bus.zero_flag = 1'b0; bus.instr_rdata = '0;
    @(negedge clk);
    rst = 1'b1;
    foreach (q[i]) begin
      if (i > 0) @(negedge clk);
      run = q[i].run;
      bus.zero_flag = q[i].zf;
      bus.instr_rdata = mem[prev];
      if (bus.push) dstk.push_back(bus.instr_addr);
      if (bus.pop && dstk.size() > 0) bus.ret_addr = dstk.pop_back();
      check("addr", 64'(bus.instr_addr), 64'(q[i].addr));
      check("fields", 64'({bus.op_code, bus.source1_choice, bus.source1, bus.source2_choice,
            bus.source2, bus.destination_choice, bus.destination}), 64'(q[i].fld));
      check("ctl", 64'({bus.push, bus.pop, busy, halted, fault}), 64'(q[i].ctl));
      prev = bus.instr_addr;
    end
  endtask

  task automatic reset_mid_exec();
    fill(0);
    mem[0] = mk(6'h01, 8'h5A);
    rst = 1'b0; run = 1'b1; bus.zero_flag = 1'b0; bus.ret_addr = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.instr_rdata = mem[0];
    repeat (2) @(negedge clk);
    check("rst_exec_op", 64'(bus.op_code), 64'h01);
    check("rst_exec_d", 64'(bus.destination), 64'h5A);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_fields", 64'({bus.op_code, bus.source1_choice, bus.source1, bus.source2_choice,
          bus.source2, bus.destination_choice, bus.destination}), 64'h0);
    check("rst_addr", 64'(bus.instr_addr), 64'h0);
    check("rst_ctl", 64'({bus.push, bus.pop, busy, halted, fault}), 64'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_resume", 64'({busy, bus.instr_addr}), 64'h100);
  endtask

  initial begin
    reset_mid_exec();
    fill(0); mem[0] = mk(6'h01, 8'h11); mem[1] = mk(OP_JMP, 8'h05);
    run_prog(10, -1, 0);
    for (int i = 0; i < 256; i++) mem[i] = mk(OP_JZ, 8'h10);
    run_prog(12, -1, 0);
    fill(0);
    for (int i = 0; i < 3; i++) mem[i] = mk(6'h07, 8'h00);
    mem[3] = mk(OP_CALL, 8'h20); mem[8'h20] = mk(OP_RET, 8'h00);
    run_prog(10, -1, 0);
    fill(0); mem[0] = mk(OP_CALL, 8'h10); mem[8'h10] = mk(OP_CALL, 8'h20); mem[8'h20] = mk(OP_CALL, 8'h30);
    run_prog(10, -1, 0);
    fill(0); mem[0] = mk(OP_RET, 8'h00);
    run_prog(10, -1, 0);
    fill(0); mem[0] = mk(OP_JMP, 8'hFF); mem[8'hFF] = mk(6'h05, 8'h00);
    run_prog(3, 1, 2);
    repeat (30) begin
      fill(1);
      run_prog(30, $urandom % 10, 1 + $urandom % 3);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
